// File: rtl/ssram_req_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : ssram_req_adapter
//  Description : Valid/ready request front-end for a synchronous byte-enable
//                SSRAM. Decodes byte addresses, issues cs/we/be/addr/wdata in
//                the acceptance cycle, and captures the one-cycle-late read
//                data into a small in-order response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ssram_req_adapter #(
  parameter int NUM_WORDS = 1024,
  parameter int DATA_LEN  = 64,
  parameter int ADDR_LEN  = 32,
  parameter int RSP_DEPTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [DATA_LEN/8-1:0]        req_be_i,
  input  logic [ADDR_LEN-1:0]          req_addr_i,
  input  logic [DATA_LEN-1:0]          req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_we_o,
  output logic                         rsp_err_o,
  output logic [DATA_LEN-1:0]          rsp_rdata_o,
  output logic                         sram_cs_o,
  output logic                         sram_we_o,
  output logic [DATA_LEN/8-1:0]        sram_be_o,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
  output logic [DATA_LEN-1:0]          sram_wdata_o,
  input  logic [DATA_LEN-1:0]          sram_rdata_i
);

  localparam int c_offs = $clog2(DATA_LEN/8);
  localparam int c_idxw = $clog2(NUM_WORDS);
  localparam int c_ptrw = $clog2(RSP_DEPTH);
  localparam int c_cntw = $clog2(RSP_DEPTH + 1);
  localparam int c_sumw = c_cntw + 1;
  localparam logic [c_ptrw-1:0] c_last_ptr = c_ptrw'(RSP_DEPTH - 1);
  localparam logic [c_cntw-1:0] c_depth    = c_cntw'(RSP_DEPTH);

  // Inflight stage: one request whose SSRAM access happened at the last edge
  logic r_inflight;
  logic r_inf_we;
  logic r_inf_err;

  // Response FIFO state
  logic [c_ptrw-1:0]   r_wr_ptr;
  logic [c_ptrw-1:0]   r_rd_ptr;
  logic [c_cntw-1:0]   r_count;
  logic [DATA_LEN-1:0] r_fifo_rdata [RSP_DEPTH];
  logic                r_fifo_we    [RSP_DEPTH];
  logic                r_fifo_err   [RSP_DEPTH];

  logic                w_err;
  logic [c_sumw-1:0]   w_occupancy;
  logic                w_ready;
  logic                w_accept;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [DATA_LEN-1:0] w_push_rdata;

  function automatic logic [c_ptrw-1:0] ptr_inc(input logic [c_ptrw-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Misaligned low bits or any address bit above the SSRAM window is an error
  assign w_err = (|req_addr_i[c_offs-1:0]) | (|req_addr_i[ADDR_LEN-1:c_offs+c_idxw]);

  // Every accepted request owns a FIFO slot from acceptance until its pop,
  // so ready only looks at registered occupancy (no valid/rsp_ready paths).
  assign w_occupancy = {1'b0, r_count} + {{c_cntw{1'b0}}, r_inflight};
  assign w_ready     = w_occupancy < c_sumw'(RSP_DEPTH);
  assign req_ready_o = w_ready;

  // Gating with rst_n_i keeps the SSRAM idle while reset is held
  assign w_accept = req_valid_i & w_ready & rst_n_i;
  assign w_issue  = w_accept & ~w_err;

  assign sram_cs_o    = w_issue;
  assign sram_we_o    = w_issue & req_we_i;
  assign sram_be_o    = w_issue ? req_be_i : '0;
  assign sram_addr_o  = req_addr_i[c_offs +: c_idxw];
  assign sram_wdata_o = req_wdata_i;

  // Latch the attributes of the request accessing the SSRAM this edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_inflight <= 1'b0;
      r_inf_we   <= 1'b0;
      r_inf_err  <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inf_we  <= req_we_i;
        r_inf_err <= w_err;
      end
    end
  end

  // Read data is only looked at for a good read; anything else stores zero
  assign w_push       = r_inflight;
  assign w_push_rdata = (!r_inf_we && !r_inf_err) ? sram_rdata_i : '0;
  assign w_pop        = (r_count != '0) & rsp_ready_i;

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible while the count covers them
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_rdata[r_wr_ptr] <= w_push_rdata;
      r_fifo_we[r_wr_ptr]    <= r_inf_we;
      r_fifo_err[r_wr_ptr]   <= r_inf_err;
    end
  end

  assign rsp_valid_o = (r_count != '0);
  assign rsp_we_o    = rsp_valid_o & r_fifo_we[r_rd_ptr];
  assign rsp_err_o   = rsp_valid_o & r_fifo_err[r_rd_ptr];
  assign rsp_rdata_o = rsp_valid_o ? r_fifo_rdata[r_rd_ptr] : '0;

  // The ready rule must make a push into a full FIFO impossible
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(r_inflight && (r_count == c_depth)));

endmodule
`default_nettype wire

// File: tb/tb_ssram_req_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssram_req_adapter
//  Description : Directed bench for ssram_req_adapter with an SSRAM model and
//                a queue-based response scoreboard checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ssram_req_adapter;

  localparam int NUM_WORDS = 1024;
  localparam int DATA_LEN  = 64;
  localparam int ADDR_LEN  = 32;
  localparam int RSP_DEPTH = 3;
  localparam logic [63:0] c_garbage = 64'hBAD0_BAD1_BAD2_BAD3;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [7:0]  req_be_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic        rsp_we_o;
  logic        rsp_err_o;
  logic [63:0] rsp_rdata_o;
  logic        sram_cs_o;
  logic        sram_we_o;
  logic [7:0]  sram_be_o;
  logic [9:0]  sram_addr_o;
  logic [63:0] sram_wdata_o;
  logic [63:0] sram_rdata_i = c_garbage;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  ssram_req_adapter #(
    .NUM_WORDS(NUM_WORDS), .DATA_LEN(DATA_LEN), .ADDR_LEN(ADDR_LEN), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
    .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input int k);
    logic [31:0] kk;
    kk = k;
    return {16'hA5A5, kk[15:0], 32'h1000_0000 + kk};
  endfunction

  // SSRAM: commits writes at the edge, returns read data after the edge
  logic [63:0] mem [NUM_WORDS];
  initial begin
    for (int k = 0; k < NUM_WORDS; k++) mem[k] = init_word(k);
    forever begin
      @(posedge clk_i);
      if (sram_cs_o && !sram_we_o) sram_rdata_i <= mem[sram_addr_o];
      else                         sram_rdata_i <= c_garbage;
      if (sram_cs_o && sram_we_o)
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) mem[sram_addr_o][b*8 +: 8] = sram_wdata_o[b*8 +: 8];
    end
  end

  // Scoreboard: expected responses in acceptance order, each visible
  // two cycles after its acceptance cycle
  typedef struct {
    logic        we;
    logic        err;
    logic [63:0] rdata;
    int          avail;
  } exp_t;

  exp_t        q[$];
  logic [63:0] ref_mem [NUM_WORDS];
  int          outstanding = 0;

  initial begin
    logic        e_ready, e_valid, acc, a_err;
    int unsigned a_idx;
    exp_t        e;
    for (int k = 0; k < NUM_WORDS; k++) ref_mem[k] = init_word(k);
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        q.delete();
        outstanding = 0;
        chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
        chk("rst_sram_cs", {63'd0, sram_cs_o}, 64'd0);
        chk("rst_rsp_we", {63'd0, rsp_we_o}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err_o}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 64'd0);
      end else begin
        e_ready = outstanding < RSP_DEPTH;
        chk("req_ready", {63'd0, req_ready_o}, {63'd0, e_ready});
        e_valid = (q.size() > 0) && (q[0].avail <= cyc);
        chk("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, e_valid});
        if (e_valid) begin
          chk("rsp_we", {63'd0, rsp_we_o}, {63'd0, q[0].we});
          chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, q[0].err});
          chk("rsp_rdata", rsp_rdata_o, q[0].rdata);
        end
        acc   = req_valid_i && e_ready;
        a_err = (req_addr_i % 8 != 0) || (req_addr_i >= 32'(NUM_WORDS * 8));
        a_idx = (req_addr_i / 8) % NUM_WORDS;
        chk("sram_cs", {63'd0, sram_cs_o}, {63'd0, acc && !a_err});
        if (acc && !a_err) begin
          chk("sram_we", {63'd0, sram_we_o}, {63'd0, req_we_i});
          chk("sram_be", {56'd0, sram_be_o}, {56'd0, req_be_i});
          chk("sram_addr", {54'd0, sram_addr_o}, 64'(a_idx));
          chk("sram_wdata", sram_wdata_o, req_wdata_i);
        end else begin
          chk("sram_we_idle", {63'd0, sram_we_o}, 64'd0);
          chk("sram_be_idle", {56'd0, sram_be_o}, 64'd0);
        end
        if (e_valid && rsp_ready_i) begin
          void'(q.pop_front());
          outstanding--;
        end
        if (acc) begin
          e.we    = req_we_i;
          e.err   = a_err;
          e.rdata = '0;
          e.avail = cyc + 2;
          if (!a_err && req_we_i) begin
            for (int b = 0; b < 8; b++)
              if (req_be_i[b]) ref_mem[a_idx][b*8 +: 8] = req_wdata_i[b*8 +: 8];
          end else if (!a_err) begin
            e.rdata = ref_mem[a_idx];
          end
          q.push_back(e);
          outstanding++;
        end
      end
    end
  end

  // Present one request until accepted; returns the acceptance cycle and
  // the word address seen on the SSRAM port in that cycle
  task automatic send(input logic we, input logic [31:0] addr, input logic [7:0] be,
                      input logic [63:0] wd, output int acc_cyc, output logic [9:0] saddr);
    acc_cyc = -1;
    saddr   = '0;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_be_i = be; req_wdata_i = wd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        acc_cyc = cyc;
        saddr   = sram_addr_o;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    n_checks++; n_errors++;
    $display("FAIL req_accept_timeout: addr %h not accepted within 20 cycles", addr);
  endtask

  // Wait for the next popped response
  task automatic wait_rsp(output logic [63:0] d, output logic e, output int c);
    d = '0; e = 1'b0; c = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o && rsp_ready_i) begin
        d = rsp_rdata_o; e = rsp_err_o; c = cyc;
        @(posedge clk_i); #1;
        return;
      end
    end
    @(posedge clk_i); #1;
    n_checks++; n_errors++;
    $display("FAIL rsp_timeout: no response within 20 cycles");
  endtask

  initial begin
    int          a0, a1, rc, acc_n, seen;
    logic [9:0]  sa;
    logic [63:0] d;
    logic        e;

    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("reset_ready", {63'd0, req_ready_o}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    @(posedge clk_i); #1;

    // Full-word write then read-back of the same word
    send(1'b1, 32'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D, a0, sa);
    chk("s1_wr_addr", {54'd0, sa}, 64'd2);
    send(1'b0, 32'h10, 8'h00, 64'd0, a1, sa);
    chk("s1_rd_addr", {54'd0, sa}, 64'd2);
    wait_rsp(d, e, rc);
    chk("s1_wr_rsp_err", {63'd0, e}, 64'd0);
    wait_rsp(d, e, rc);
    chk("s1_rd_data", d, 64'hDEADBEEF_CAFEF00D);
    chk("s1_rd_err", {63'd0, e}, 64'd0);
    chk("s1_latency", 64'(rc - a1), 64'd2);

    // Single-byte write merges into the stored word
    send(1'b1, 32'h10, 8'h01, 64'h11, a0, sa);
    send(1'b0, 32'h10, 8'h00, 64'd0, a1, sa);
    wait_rsp(d, e, rc);
    wait_rsp(d, e, rc);
    chk("s2_rd_data", d, 64'hDEADBEEF_CAFEF011);

    // Zero byte enables: access issued, nothing changes, no error
    send(1'b1, 32'h18, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, a0, sa);
    send(1'b0, 32'h18, 8'h00, 64'd0, a1, sa);
    wait_rsp(d, e, rc);
    chk("zbe_err", {63'd0, e}, 64'd0);
    wait_rsp(d, e, rc);
    chk("zbe_rd_data", d, init_word(3));

    // Misaligned and out-of-range reads
    send(1'b0, 32'h13, 8'h00, 64'd0, a0, sa);
    send(1'b0, 32'h2000, 8'h00, 64'd0, a1, sa);
    wait_rsp(d, e, rc);
    chk("s3_misal_err", {63'd0, e}, 64'd1);
    chk("s3_misal_data", d, 64'd0);
    wait_rsp(d, e, rc);
    chk("s3_oor_err", {63'd0, e}, 64'd1);
    chk("s3_oor_data", d, 64'd0);

    // Backpressure: five reads with the consumer stalled
    rsp_ready_i = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid_i = (acc_n < 5); req_we_i = 1'b0; req_addr_i = 32'h100 + 32'(acc_n) * 8;
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) acc_n++;
      @(posedge clk_i); #1;
    end
    chk("s4_accepts_stalled", 64'(acc_n), 64'd3);
    chk("s4_rsp_valid_held", {63'd0, rsp_valid_o}, 64'd1);
    chk("s4_ready_low", {63'd0, req_ready_o}, 64'd0);
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 20 && acc_n < 5; c++) begin
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h100 + 32'(acc_n) * 8;
      @(negedge clk_i);
      if (req_ready_o) acc_n++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    chk("s4_accepts_total", 64'(acc_n), 64'd5);
    repeat (8) @(posedge clk_i);
    #1;

    // Streaming: one accept per cycle with the consumer always ready
    acc_n = 0;
    for (int k = 0; k < 16; k++) begin
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'(k) * 8;
      @(negedge clk_i);
      if (req_ready_o) acc_n++;
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    chk("s5_stream_accepts", 64'(acc_n), 64'd16);
    repeat (6) @(posedge clk_i);
    #1;

    // Reset with the FIFO full and a request still offered
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h40;
    repeat (6) @(posedge clk_i);
    #1;
    chk("s6_full_ready", {63'd0, req_ready_o}, 64'd0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("s6_rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("s6_rst_sram_cs", {63'd0, sram_cs_o}, 64'd0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(posedge clk_i); #3 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("s6_post_ready", {63'd0, req_ready_o}, 64'd1);
    rsp_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    chk("s6_no_stale", 64'(seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssram_req_adapter.md
Name: ssram_req_adapter

Overview:
- Request/response front-end that sits directly upstream of the synchronous byte-enable SSRAM.
- Converts a valid/ready byte-addressed request channel into SSRAM control and data: cs, we, be, word address, wdata.
- Captures the SSRAM's one-cycle-late read data into a small response FIFO so the consumer can apply backpressure.
- Flags misaligned and out-of-range accesses without touching the memory.

Parameters:
- NUM_WORDS, 1024, SSRAM depth in words; power of 2.
- DATA_LEN, 64, word width in bits; power of 2, at least 16.
- ADDR_LEN, 32, request byte-address width.
- RSP_DEPTH, 3, response FIFO entries; minimum 2. A value of 3 or more gives one request per cycle with no combinational rsp_ready_i to req_ready_o path.

Ports:
- clk_i  in  1  main clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_we_i  in  1  1 = write, 0 = read
- req_be_i  in  DATA_LEN/8  byte enables; bit N selects byte N (little endian)
- req_addr_i  in  ADDR_LEN  byte address
- req_wdata_i  in  DATA_LEN  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_we_o  out  1  echoes req_we_i of the answered request
- rsp_err_o  out  1  request was misaligned or out of range
- rsp_rdata_o  out  DATA_LEN  read data; 0 for writes and errored requests
- sram_cs_o  out  1  SSRAM chip select
- sram_we_o  out  1  SSRAM write enable
- sram_be_o  out  DATA_LEN/8  SSRAM byte enables
- sram_addr_o  out  $clog2(NUM_WORDS)  SSRAM word address
- sram_wdata_o  out  DATA_LEN  SSRAM write data
- sram_rdata_i  in  DATA_LEN  SSRAM read data, valid the cycle after a read is issued

Behaviour:
- Address decode:
  - OFFS = $clog2(DATA_LEN/8); IDXW = $clog2(NUM_WORDS).
  - Word index = req_addr_i[OFFS +: IDXW].
  - err = (req_addr_i[OFFS-1:0] != 0) OR (req_addr_i[ADDR_LEN-1:OFFS+IDXW] != 0).
- Acceptance:
  - A request is accepted when req_valid_i && req_ready_o.
  - req_ready_o = (fifo_count + inflight_q) < RSP_DEPTH.
  - req_ready_o is registered-state only and never depends on req_valid_i or rsp_ready_i.
- Issue (combinational, same cycle as acceptance):
  - sram_cs_o = accept && !err.
  - sram_we_o = req_we_i; sram_be_o = req_be_i; sram_addr_o = word index; sram_wdata_o = req_wdata_i.
  - When sram_cs_o = 0, sram_we_o and sram_be_o are 0.
  - Errored requests never assert sram_cs_o.
- Inflight stage:
  - On accept, inflight_q <= 1 and {we, err} are latched; otherwise inflight_q <= 0.
  - In the next cycle, a FIFO entry is pushed:
    - rdata = sram_rdata_i for a non-errored read; 0 otherwise.
    - we and err as latched.
  - sram_rdata_i is sampled only for inflight non-errored reads; X elsewhere must not propagate.
- Latency:
  - Accept in cycle T: SSRAM access at the edge ending T, push at the edge ending T+1, rsp_valid_o high in T+2 at the earliest.
- Response FIFO:
  - rsp_valid_o = fifo_count != 0; rsp_* outputs present the head entry.
  - Pop on rsp_valid_o && rsp_ready_i.
  - Simultaneous push and pop leaves the count unchanged and preserves order.
  - Pointers wrap modulo RSP_DEPTH.
  - The ready rule guarantees overflow is impossible; an assertion checks that a push never occurs while full.
- Ordering: responses are returned strictly in acceptance order.
- Hazards: a read accepted the cycle after a write to the same word returns the written data. The SSRAM commits at the edge, so the adapter needs no forwarding.
- Zero byte enables: a write with be = 0 still issues cs/we, modifies nothing, and returns a response with err = 0.
- Reset (asynchronous, any time, including with requests inflight or the FIFO full):
  - fifo_count = 0, pointers = 0, inflight_q = 0.
  - rsp_valid_o = 0, rsp_we_o = 0, rsp_err_o = 0, rsp_rdata_o = 0.
  - req_ready_o = 1 after reset.
  - sram_cs_o = 0 while rst_n_i is low.
  - Pending responses are discarded.

Test Plan:
- Write 0xDEADBEEF_CAFEF00D, be = 0xFF, to 0x10, then read 0x10 with rsp_ready_i = 1:
  - required: sram_addr_o = 2 on both requests; read response rdata = 0xDEADBEEF_CAFEF00D, err = 0, two cycles after acceptance.
- Write 0x11 with be = 0x01 to 0x10 (word from scenario 1), then read 0x10:
  - required: rdata = 0xDEADBEEF_CAFEF011.
- Read 0x13 (misaligned), then read 0x2000 (out of range at the defaults):
  - required: sram_cs_o stays 0 for both; each response has err = 1, rdata = 0.
- Five back-to-back reads with rsp_ready_i held at 0:
  - required: req_ready_o falls after 3 accepts; rsp_valid_o stays high.
  - Then raise rsp_ready_i: responses drain in order, and req_ready_o rises the cycle after the first pop.
- Stream 16 reads with req_valid_i and rsp_ready_i both held at 1:
  - required: one accept per cycle and no bubbles; response k equals the data at word k.
- Fill the FIFO, then pulse rst_n_i low mid-stream:
  - required: rsp_valid_o = 0 and sram_cs_o = 0 immediately.
  - After release: req_ready_o = 1 and no stale responses appear.
